reg_share_arb: RTL

Round-robin arbiter and sequencer that shares one W-bit holding register (din/dout style, as used by the lab datapath) between N requesters. Each granted requester gets one access slot in which it may write the register or only read it. The block sits between the requester modules and the shared register, and owns the register itself.

---
 rtl/reg_share_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/reg_share_arb.sv
// Round-robin arbiter that shares one W-bit holding register among N requesters.
// Optional burst-hold (lock) support is enabled with `define REG_SHARE_ARB_LOCK_EN.
module reg_share_arb #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   we,
    input  logic [N*W-1:0] din,
`ifdef REG_SHARE_ARB_LOCK_EN
    input  logic [N-1:0]   lock,
`endif
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   dout,
    output logic           busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic [PW-1:0] gidx, gidx_nxt;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_after;
    logic [N-1:0]  gnt_nxt;
    logic [W-1:0]  dout_nxt;
    logic          found;
    logic          hold;
    int            idx;

`ifdef REG_SHARE_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0] lock_cnt, lock_cnt_nxt;

    assign hold = lock[gidx] & req[gidx] & (int'(lock_cnt) < MAX_LOCK - 1);
`else
    assign hold = 1'b0;
`endif

    // Search upward from ptr with wrap; the slot holder just served sits last.
    always_comb begin
        // NOTE: every variable gets a default before any branch, otherwise a latch is inferred.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign ptr_after = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        dout_nxt  = dout;
`ifdef REG_SHARE_ARB_LOCK_EN
        lock_cnt_nxt = lock_cnt;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    gidx_nxt     = win;
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                end
            end
            GRANT: begin
                // An abandoned slot (req dropped) never writes.
                if (req[gidx] && we[gidx]) begin
                    dout_nxt = din[gidx*W +: W];
                end
                if (hold) begin
`ifdef REG_SHARE_ARB_LOCK_EN
                    lock_cnt_nxt = lock_cnt + 1'b1;
`endif
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = ptr_after;
`ifdef REG_SHARE_ARB_LOCK_EN
                    lock_cnt_nxt = '0;
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gidx     <= '0;
            ptr      <= '0;
            dout     <= '0;
`ifdef REG_SHARE_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gidx     <= gidx_nxt;
            ptr      <= ptr_nxt;
            dout     <= dout_nxt;
`ifdef REG_SHARE_ARB_LOCK_EN
            lock_cnt <= lock_cnt_nxt;
`endif
        end
    end

    assign busy = (state == GRANT);

endmodule
